rr_arb4_moore: RTL and testbench
================================

Name: rr_arb4_moore

Overview:
- Four-requester round-robin arbiter built as a Moore FSM. It shares one downstream resource among requesters 0..3, for example the 2-bit-input sequence FSMs in this FSM library.
- All grant outputs decode from registered state only; no combinational path runs from req to gnt.
- Sits between requester FSMs and the shared resource, and issues one exclusive, level-held grant at a time.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles before forced handoff; used only with ARB_TIMEOUT_EN; legal 2..2**CNT_W-1.
- CNT_W, 4: width of the hold counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  4  level request per requester; held high while the resource is needed
- gnt  output  4  one-hot grant; all-zero when idle
- gnt_id  output  2  index of the current owner; 0 when idle
- gnt_vld  output  1  high when some requester owns the resource
- timeout  output  1  one-cycle pulse on a forced handoff; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Registered state:
  - mode: IDLE or OWN.
  - owner[1:0].
  - last[1:0]: most recent owner, which sets the round-robin pointer.
  - hold_cnt[CNT_W-1:0].
- Reset (async, immediate):
  - mode=IDLE, owner=0, last=3 (so requester 0 wins first), hold_cnt=0.
  - Outputs gnt=0000, gnt_id=0, gnt_vld=0, timeout=0.
- Round-robin pick: first set bit of the candidate vector, searching last+1, last+2, last+3, last in that order, modulo 4.
- IDLE:
  - req==0: stay IDLE.
  - Otherwise: go to OWN with owner=pick(req), last=owner, hold_cnt=1.
  - gnt appears in the cycle after req is first sampled (latency 1 clock).
- OWN, owner's request dropped (req[owner]==0):
  - Other requests pending: move directly to the next RR pick with no idle bubble. Candidates exclude the old owner. Update last; hold_cnt=1.
  - No other request pending: go to IDLE. last keeps the old owner.
- OWN, req[owner]==1: stay and increment hold_cnt, saturating at 2**CNT_W-1.
- Outputs (Moore):
  - gnt = one-hot(owner) when mode==OWN, else 0.
  - gnt_id = owner when mode==OWN, else 0.
  - gnt_vld = (mode==OWN).
- Boundaries:
  - Simultaneous requests from IDLE: RR pointer decides; with last=3, requester 0 wins.
  - All four requesting continuously, each dropping after 1 cycle: order 0,1,2,3,0,...
  - Owner drops and re-raises in the same cycle it is released: its request is treated as new and goes to the back of RR order.
  - Requesters that are not the owner may toggle freely without disturbing the current grant.
  - Reset mid-grant: gnt goes to 0 immediately (asynchronous), and the first post-reset winner is requester 0.
- Invariants: gnt is always one-hot or zero, and gnt_id matches gnt.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - In OWN with req[owner]==1, hold_cnt==MAX_HOLD, and another request pending: forced handoff to the RR pick, excluding the owner.
  - timeout=1 for exactly the first cycle of the new grant (registered pulse); hold_cnt=1.
  - If no other request is pending, the owner keeps the grant and hold_cnt saturates at MAX_HOLD. A timeout fires on the first cycle another request is seen.
- ARB_TIMEOUT_EN undefined: no forced handoff; timeout tied to 0; hold_cnt may be optimised away.

Decomposition:
- Package arb_pkg:
  - mode encoding constants: MODE_IDLE=1'b0, MODE_OWN=1'b1.
  - requester count constant N_REQ=4.
  - function rr_pick(vec[3:0], last[1:0]) returning 2-bit index.
  - function onehot4(idx[1:0]).
- One natural sub-module: rr_pick4, a combinational round-robin priority picker with inputs cand[3:0] and last[1:0] and outputs idx[1:0] and any. It is instanced once in the top.

Test Plan:
- Reset then single request: rst=1→0, req=0100 at cycle 2 → gnt=0100, gnt_id=2, gnt_vld=1 at cycle 3; req=0 → gnt=0000 next cycle.
- Simultaneous start: req=1111 from reset → grant 0. Each owner drops req for 1 cycle after 2 cycles of grant → grant sequence 0,1,2,3,0 with no idle cycle between owners.
- Handoff skip: owner 1, req=1011, owner 1 drops → next gnt_id=3, since 2 is not requesting. Then with req=0001 → gnt_id=0.
- Async reset mid-grant: owner 2 granted, rst pulsed between edges → gnt=0000 immediately. After release, req=1100 → gnt_id=2, since last resets to 3 and the pick order is 0,1,2 and 2 is the lowest set bit of 1100 in that order.
- ARB_TIMEOUT_EN, MAX_HOLD=4: req=0011 held steady → owner 0 for 4 cycles, then gnt_id=1 with timeout=1 for one cycle. After 4 more cycles it returns to 0.
- ARB_TIMEOUT_EN, lone requester: req=0001 held 20 cycles → gnt stays 0001 and timeout stays 0. Raise req[3] → the next cycle after sampling gives gnt_id=3 and timeout=1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   MODE_IDLE / MODE_OWN : encodings of the arbiter mode register
//   N_REQ                : number of requesters
//   rr_pick()            : round-robin index pick starting after 'last'
//   onehot4()            : 2-bit index to 4-bit one-hot decode
package arb_pkg;

    localparam logic MODE_IDLE = 1'b0;
    localparam logic MODE_OWN  = 1'b1;

    localparam int unsigned N_REQ = 4;

    typedef enum logic {
        ModeIdle = MODE_IDLE,
        ModeOwn  = MODE_OWN
    } mode_e;

    // First set bit of vec searching last+1, last+2, last+3, last (mod 4).
    // Returns 'last' when vec is empty; callers qualify with |vec.
    function automatic logic [1:0] rr_pick(input logic [3:0] vec, input logic [1:0] last);
        logic [1:0] res;
        logic       found;
        logic [1:0] idx;
        res   = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && vec[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_arb4_moore_if.sv
// Requester-side bus of the round-robin arbiter.
//   req     : level request per requester
//   gnt     : one-hot grant, zero when idle
//   gnt_id  : index of current owner, 0 when idle
//   gnt_vld : some requester owns the resource
//   timeout : one-cycle pulse on a forced handoff
// Modports: master = requester side, slave = arbiter side.
interface rr_arb4_moore_if;

    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_vld,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_vld,
        output timeout
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin priority picker for four candidates.
//   cand : candidate vector
//   last : most recent owner; search starts at last+1
//   idx  : picked index (valid only when any is high)
//   any  : at least one candidate present
module rr_pick4
    import arb_pkg::*;
(
    input  logic [3:0] cand,
    input  logic [1:0] last,
    output logic [1:0] idx,
    output logic       any
);

    assign idx = rr_pick(cand, last);
    assign any = |cand;

endmodule

// File: rtl/rr_arb4_moore.sv
// Four-requester round-robin arbiter, Moore FSM: grant outputs decode from
// registered state only, so there is no combinational req -> gnt path.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : rr_arb4_moore_if.slave (req in; gnt, gnt_id, gnt_vld, timeout out)
// Optional build macro ARB_TIMEOUT_EN: forced handoff after MAX_HOLD
// consecutive grant cycles when another requester is waiting.
module rr_arb4_moore
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic           clk,
    input  logic           rst,
    rr_arb4_moore_if.slave bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_bad_max_hold
        $error("MAX_HOLD out of range for CNT_W");
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HoldSat = CNT_W'(MAX_HOLD);
`else
    localparam logic [CNT_W-1:0] HoldSat = '1;
`endif

    mode_e            mode_q, mode_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             timeout_d;

    logic [3:0] cand;
    logic [1:0] pick_idx;
    logic       pick_any;

    // While owning, the current owner is never a handoff candidate, so a
    // release-and-re-raise goes to the back of the round-robin order.
    assign cand = (mode_q == ModeOwn) ? (bus.req & ~onehot4(owner_q)) : bus.req;

    rr_pick4 u_pick (
        .cand (cand),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        mode_d    = mode_q;
        owner_d   = owner_q;
        last_d    = last_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (mode_q)
            ModeIdle: begin
                if (pick_any) begin
                    mode_d  = ModeOwn;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    hold_d  = CNT_W'(1);
                end
            end
            ModeOwn: begin
                if (!bus.req[owner_q]) begin
                    if (pick_any) begin
                        owner_d = pick_idx;
                        last_d  = pick_idx;
                        hold_d  = CNT_W'(1);
                    end else begin
                        mode_d = ModeIdle;
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (hold_q == HoldSat && pick_any) begin
                        owner_d   = pick_idx;
                        last_d    = pick_idx;
                        hold_d    = CNT_W'(1);
                        timeout_d = 1'b1;
                    end else
`endif
                    if (hold_q != HoldSat) begin
                        hold_d = hold_q + CNT_W'(1);
                    end
                end
            end
            default: mode_d = ModeIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= ModeIdle;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
            hold_q  <= '0;
        end else begin
            mode_q  <= mode_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = timeout_d;
    assign bus.timeout    = 1'b0;
`endif

    assign bus.gnt_vld = (mode_q == ModeOwn);
    assign bus.gnt     = (mode_q == ModeOwn) ? onehot4(owner_q) : 4'b0000;
    assign bus.gnt_id  = (mode_q == ModeOwn) ? owner_q : 2'd0;

endmodule

// File: tb/tb_rr_arb4_moore.sv
// Directed self-checking bench for rr_arb4_moore. Inputs change and outputs
// are sampled 1 time unit after each rising edge. Timeout scenarios are
// built only when ARB_TIMEOUT_EN is defined.
module tb_rr_arb4_moore;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    rr_arb4_moore_if bus ();

    rr_arb4_moore #(
        .MAX_HOLD (4),
        .CNT_W    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected gnt is rebuilt from the expected owner, not from gnt_id.
    task automatic check_grant(input string tag, input logic vld, input logic [1:0] id,
                               input logic tmo);
        logic [3:0] exp_gnt;
        exp_gnt = vld ? (4'b0001 << id) : 4'b0000;
        check({tag, ".gnt"},     32'(bus.gnt),     32'(exp_gnt));
        check({tag, ".gnt_id"},  32'(bus.gnt_id),  vld ? 32'(id) : 32'd0);
        check({tag, ".gnt_vld"}, 32'(bus.gnt_vld), 32'(vld));
        check({tag, ".timeout"}, 32'(bus.timeout), 32'(tmo));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.req = 4'b0000;
        #2;
        check_grant("reset", 1'b0, 2'd0, 1'b0);
        tick();
        rst = 1'b0;

        // Single request, latency one clock, release back to idle.
        tick();
        bus.req = 4'b0100;
        tick();
        check_grant("single", 1'b1, 2'd2, 1'b0);
        bus.req = 4'b0000;
        tick();
        check_grant("single_rel", 1'b0, 2'd0, 1'b0);

        // All four from reset: 0,1,2,3,0 with no idle gaps.
        pulse_reset();
        bus.req = 4'b1111;
        tick();
        for (int k = 0; k < 4; k++) begin
            check_grant($sformatf("rr%0d_a", k), 1'b1, 2'(k), 1'b0);
            tick();
            check_grant($sformatf("rr%0d_b", k), 1'b1, 2'(k), 1'b0);
            bus.req = 4'b1111 & ~(4'b0001 << k);
            tick();
            bus.req = 4'b1111;
        end
        check_grant("rr_wrap", 1'b1, 2'd0, 1'b0);

        // Handoff skips a non-requester: owner 1 drops with 0 and 3 waiting.
        bus.req = 4'b1010;
        tick();
        check_grant("skip_own1", 1'b1, 2'd1, 1'b0);
        bus.req = 4'b1011;
        tick();
        check_grant("skip_hold1", 1'b1, 2'd1, 1'b0);
        bus.req = 4'b1001;
        tick();
        check_grant("skip_to3", 1'b1, 2'd3, 1'b0);
        bus.req = 4'b0001;
        tick();
        check_grant("skip_to0", 1'b1, 2'd0, 1'b0);

        // Non-owners toggling leave the grant alone.
        bus.req = 4'b0101;
        tick();
        check_grant("toggle_a", 1'b1, 2'd0, 1'b0);
        bus.req = 4'b0011;
        tick();
        check_grant("toggle_b", 1'b1, 2'd0, 1'b0);
        bus.req = 4'b0000;
        tick();
        check_grant("idle", 1'b0, 2'd0, 1'b0);

        // Asynchronous reset mid-grant, then pointer restarts at 0.
        bus.req = 4'b0100;
        tick();
        check_grant("pre_rst", 1'b1, 2'd2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_grant("async_rst", 1'b0, 2'd0, 1'b0);
        bus.req = 4'b1100;
        #1;
        rst = 1'b0;
        tick();
        check_grant("post_rst", 1'b1, 2'd2, 1'b0);
        bus.req = 4'b0000;
        tick();

`ifdef ARB_TIMEOUT_EN
        // Two steady requesters: forced handoff every MAX_HOLD cycles.
        pulse_reset();
        bus.req = 4'b0011;
        tick();
        check_grant("to_own0", 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_grant($sformatf("to_hold0_%0d", i), 1'b1, 2'd0, 1'b0);
        end
        tick();
        check_grant("to_swap1", 1'b1, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_grant($sformatf("to_hold1_%0d", i), 1'b1, 2'd1, 1'b0);
        end
        tick();
        check_grant("to_swap0", 1'b1, 2'd0, 1'b1);

        // Lone requester keeps the grant; a newcomer triggers timeout at once.
        bus.req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i % 5 == 4) begin
                check_grant($sformatf("lone_%0d", i), 1'b1, 2'd0, 1'b0);
            end
        end
        bus.req = 4'b1001;
        tick();
        check_grant("lone_to3", 1'b1, 2'd3, 1'b1);
        tick();
        check_grant("lone_to3_b", 1'b1, 2'd3, 1'b0);
        bus.req = 4'b0000;
        tick();
`else
        // Without the timeout feature a steady owner is never preempted.
        pulse_reset();
        bus.req = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i % 4 == 3) begin
                check_grant($sformatf("no_to_%0d", i), 1'b1, 2'd0, 1'b0);
            end
        end
        bus.req = 4'b0000;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
